// File: rtl/vga_pkg.sv
// Shared VGA text-overlay constants and the reveal FSM state type.
package vga_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 16;
    localparam int BOX_W     = TEXT_COLS * CHAR_W;
    localparam int BOX_H     = TEXT_ROWS * CHAR_H;
    localparam int PIPE_LAT  = 3;

    typedef enum logic {
        REVEAL = 1'b0,
        DONE   = 1'b1
    } reveal_state_t;

endpackage

// File: rtl/reveal_sequencer.sv
// Typewriter reveal sequencer: detects frame starts on vblnk and advances the
// count of visible characters every REVEAL_FRAMES frames.
module reveal_sequencer
    import vga_pkg::*;
#(
    parameter int REVEAL_FRAMES = 4
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vblnk_in,
    input  logic       restart,
    output logic [8:0] reveal_cnt,
    output logic       done
);

    localparam logic [7:0] FRAME_LAST = 8'(REVEAL_FRAMES - 1);
    localparam logic [8:0] REVEAL_MAX = 9'(TEXT_COLS * TEXT_ROWS);

    reveal_state_t state_reg, state_next;
    logic [7:0]    frame_cnt_reg, frame_cnt_next;
    logic [8:0]    reveal_cnt_reg, reveal_cnt_next;
    logic          restart_pend_reg, restart_pend_next;
    logic          vblnk_prev_reg;
    logic          frame_tick;

    // Rising edge of vblnk marks the start of a new frame.
    assign frame_tick = vblnk_in & ~vblnk_prev_reg;

    // State register for edge detect, counters, pending restart and FSM.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev_reg   <= 1'b0;
            state_reg        <= REVEAL;
            frame_cnt_reg    <= '0;
            reveal_cnt_reg   <= '0;
            restart_pend_reg <= 1'b0;
        end else begin
            vblnk_prev_reg   <= vblnk_in;
            state_reg        <= state_next;
            frame_cnt_reg    <= frame_cnt_next;
            reveal_cnt_reg   <= reveal_cnt_next;
            restart_pend_reg <= restart_pend_next;
        end
    end

    // Next-state logic; all changes happen only at a frame tick so the text
    // on screen is stable for a whole frame.
    always_comb begin
        state_next        = state_reg;
        frame_cnt_next    = frame_cnt_reg;
        reveal_cnt_next   = reveal_cnt_reg;
        restart_pend_next = restart_pend_reg | restart;

        if (frame_tick) begin
            if (restart_pend_reg || restart) begin
                // A pending restart wins over any increment in this frame.
                state_next        = REVEAL;
                frame_cnt_next    = '0;
                reveal_cnt_next   = '0;
                restart_pend_next = 1'b0;
            end else begin
                case (state_reg)
                    REVEAL: begin
                        if (frame_cnt_reg == FRAME_LAST) begin
                            frame_cnt_next = '0;
                            if (reveal_cnt_reg != REVEAL_MAX) begin
                                reveal_cnt_next = reveal_cnt_reg + 9'd1;
                            end
                            if (reveal_cnt_reg == REVEAL_MAX - 9'd1) begin
                                state_next = DONE;
                            end
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 8'd1;
                        end
                    end
                    DONE: begin
                        // Fully revealed: frame ticks are ignored.
                    end
                    default: begin
                        state_next = REVEAL;
                    end
                endcase
            end
        end
    end

    assign reveal_cnt = reveal_cnt_reg;
    assign done       = (state_reg == DONE);

endmodule

// File: rtl/text_reveal_ctl.sv
// Text-box overlay stage: addresses the char/font ROMs from the beam position,
// aligns timing to the ROM latency and composites revealed glyph pixels.
module text_reveal_ctl
    import vga_pkg::*;
#(
    parameter logic [10:0] XPOS          = 11'd48,
    parameter logic [10:0] YPOS          = 11'd64,
    parameter int          REVEAL_FRAMES = 4,
    parameter logic [11:0] TEXT_COLOR    = 12'hFFF
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        restart,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    input  logic [7:0]  char_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        done
);

    localparam logic [10:0] BOX_W11 = 11'(BOX_W);
    localparam logic [10:0] BOX_H11 = 11'(BOX_H);
    localparam int          TIM_W   = 26;

    logic [10:0] dx, dy;
    logic        in_box;
    logic [TIM_W-1:0] tim_in;

    logic [7:0]  char_xy_reg;
    logic [3:0]  char_line_reg;
    logic        in_box_s1_reg, in_box_s2_reg;
    logic [2:0]  dxl_s1_reg, dxl_s2_reg;
    logic [11:0] rgb_s1_reg, rgb_s2_reg;
    logic [7:0]  char_xy_s2_reg;
    logic [11:0] rgb_next, rgb_out_reg;

    logic [8:0]  reveal_cnt;
    logic        revealed;
    logic        pix_bit;
    logic        blank_s2;

    // Unsigned offsets; the >= guards stop the wrapped values left/above the
    // box from aliasing into it.
    assign dx     = hcount_in - XPOS;
    assign dy     = vcount_in - YPOS;
    assign in_box = (hcount_in >= XPOS) && (dx < BOX_W11) &&
                    (vcount_in >= YPOS) && (dy < BOX_H11);

    assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

    // Timing delay line, one register per pipeline stage.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_tim
            logic [TIM_W-1:0] stage_reg;
            if (gi == 0) begin : g_head
                // First stage samples the incoming timing bundle.
                always_ff @(posedge pclk or negedge rst_n) begin
                    if (!rst_n) stage_reg <= '0;
                    else        stage_reg <= tim_in;
                end
            end else begin : g_tail
                // Later stages pass the previous stage along.
                always_ff @(posedge pclk or negedge rst_n) begin
                    if (!rst_n) stage_reg <= '0;
                    else        stage_reg <= g_tim[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    // Stage 1: ROM address is registered even outside the box.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy_reg   <= '0;
            char_line_reg <= '0;
            in_box_s1_reg <= 1'b0;
            dxl_s1_reg    <= '0;
            rgb_s1_reg    <= '0;
        end else begin
            char_xy_reg   <= {dy[7:4], dx[6:3]};
            char_line_reg <= dy[3:0];
            in_box_s1_reg <= in_box;
            dxl_s1_reg    <= dx[2:0];
            rgb_s1_reg    <= rgb_in;
        end
    end

    // Stage 2: hold pixel context while the font ROM row arrives.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            in_box_s2_reg  <= 1'b0;
            dxl_s2_reg     <= '0;
            rgb_s2_reg     <= '0;
            char_xy_s2_reg <= '0;
        end else begin
            in_box_s2_reg  <= in_box_s1_reg;
            dxl_s2_reg     <= dxl_s1_reg;
            rgb_s2_reg     <= rgb_s1_reg;
            char_xy_s2_reg <= char_xy_reg;
        end
    end

    assign blank_s2 = g_tim[1].stage_reg[1] | g_tim[1].stage_reg[0];
    assign revealed = ({1'b0, char_xy_s2_reg} < reveal_cnt);
    assign pix_bit  = char_pixels[3'd7 - dxl_s2_reg];

    // Compositing: blanking forces black, revealed set glyph pixels win over
    // the background.
    always_comb begin
        rgb_next = rgb_s2_reg;
        if (blank_s2) begin
            rgb_next = 12'h000;
        end else if (in_box_s2_reg && revealed && pix_bit) begin
            rgb_next = TEXT_COLOR;
        end
    end

    // Stage 3: output pixel register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) rgb_out_reg <= '0;
        else        rgb_out_reg <= rgb_next;
    end

    reveal_sequencer #(
        .REVEAL_FRAMES(REVEAL_FRAMES)
    ) u_seq (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .vblnk_in  (vblnk_in),
        .restart   (restart),
        .reveal_cnt(reveal_cnt),
        .done      (done)
    );

    assign char_xy   = char_xy_reg;
    assign char_line = char_line_reg;
    assign rgb_out   = rgb_out_reg;
    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} =
        g_tim[PIPE_LAT-1].stage_reg;

endmodule

// File: tb/tb_text_reveal_ctl.sv
// Bench for text_reveal_ctl: two instances (1 and 2 frames per character)
// share stimulus; a position-based reference model predicts every output.
module tb_text_reveal_ctl;

    localparam int X0 = 48;
    localparam int Y0 = 64;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
        logic [11:0] bg;
    } samp_t;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb, restart;
    logic [11:0] bg;

    logic [7:0]  pix    [2];
    logic [7:0]  xy_o   [2];
    logic [3:0]  line_o [2];
    logic [10:0] hc_o   [2];
    logic [10:0] vc_o   [2];
    logic        hs_o [2], vs_o [2], hb_o [2], vb_o [2], done_o [2];
    logic [11:0] rgb_o  [2];

    logic [7:0]  font [4096];

    int checks = 0;
    int errors = 0;

    // reference model state, index 0: 1 frame/char, index 1: 2 frames/char
    int     rf     [2] = '{1, 2};
    int     m_rev  [2];
    int     m_fc   [2];
    bit     m_pend [2];
    bit     m_done [2];
    bit     m_prev_vb;
    samp_t  h1, h2;

    logic [11:0] exp_rgb [2];
    bit          exp_done [2];
    logic [7:0]  exp_xy;
    logic [3:0]  exp_line;
    logic [25:0] exp_tim;
    logic [7:0]  obs_xy, sav_xy;
    logic [3:0]  obs_line, sav_line;

    always #5 pclk = ~pclk;

    text_reveal_ctl #(.REVEAL_FRAMES(1)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb),
        .rgb_in(bg), .restart(restart), .char_xy(xy_o[0]), .char_line(line_o[0]),
        .char_pixels(pix[0]), .hcount_out(hc_o[0]), .vcount_out(vc_o[0]),
        .hsync_out(hs_o[0]), .vsync_out(vs_o[0]), .hblnk_out(hb_o[0]),
        .vblnk_out(vb_o[0]), .rgb_out(rgb_o[0]), .done(done_o[0]));

    text_reveal_ctl #(.REVEAL_FRAMES(2)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb),
        .rgb_in(bg), .restart(restart), .char_xy(xy_o[1]), .char_line(line_o[1]),
        .char_pixels(pix[1]), .hcount_out(hc_o[1]), .vcount_out(vc_o[1]),
        .hsync_out(hs_o[1]), .vsync_out(vs_o[1]), .hblnk_out(hb_o[1]),
        .vblnk_out(vb_o[1]), .rgb_out(rgb_o[1]), .done(done_o[1]));

    // char ROM + font ROM chain: one registered cycle from address to row
    always @(posedge pclk) begin
        pix[0] <= font[{xy_o[0], line_o[0]}];
        pix[1] <= font[{xy_o[1], line_o[1]}];
    end

    // What the screen should show at a beam position given a revealed count.
    function automatic logic [11:0] model_pixel(samp_t s, int rev);
        int h, v, idx, line, px;
        h = int'(s.h);
        v = int'(s.v);
        if (s.hb || s.vb) return 12'h000;
        if (h >= X0 && h < X0 + 128 && v >= Y0 && v < Y0 + 256) begin
            idx  = ((v - Y0) / 16) * 16 + (h - X0) / 8;
            line = (v - Y0) % 16;
            px   = (h - X0) % 8;
            if (idx < rev && font[idx * 16 + line][7 - px]) return 12'hFFF;
        end
        return s.bg;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rev[k] = 0; m_fc[k] = 0; m_pend[k] = 0; m_done[k] = 0;
        end
        m_prev_vb = 0;
        h1 = '0;
        h2 = '0;
    endtask

    // One clock: predicts the outputs seen just after the edge.
    task automatic cycle();
        samp_t cur;
        bit    tick;
        int    dxi, dyi;
        cur = '{h: hc, v: vc, hs: hs, vs: vs, hb: hb, vb: vb, bg: bg};
        @(posedge pclk);
        for (int k = 0; k < 2; k++) exp_rgb[k] = model_pixel(h2, m_rev[k]);
        exp_tim = {h2.h, h2.v, h2.hs, h2.vs, h2.hb, h2.vb};
        tick = cur.vb && !m_prev_vb;
        m_prev_vb = cur.vb;
        for (int k = 0; k < 2; k++) begin
            if (tick) begin
                if (m_pend[k] || restart) begin
                    m_rev[k] = 0; m_fc[k] = 0; m_done[k] = 0; m_pend[k] = 0;
                end else if (!m_done[k]) begin
                    m_fc[k]++;
                    if (m_fc[k] == rf[k]) begin
                        m_fc[k] = 0;
                        m_rev[k]++;
                        if (m_rev[k] == 256) m_done[k] = 1;
                    end
                end
            end else if (restart) begin
                m_pend[k] = 1;
            end
            exp_done[k] = m_done[k];
        end
        dxi = (int'(cur.h) - X0) & 2047;
        dyi = (int'(cur.v) - Y0) & 2047;
        exp_xy   = 8'(((dyi / 16) % 16) * 16 + (dxi / 8) % 16);
        exp_line = 4'(dyi % 16);
        h2 = h1;
        h1 = cur;
        #1;
    endtask

    task automatic frame_tick();
        vb = 1; cycle();
        vb = 0; cycle();
    endtask

    task automatic reset_dut();
        hc = 0; vc = 0; hs = 0; vs = 0; hb = 0; vb = 0; bg = 0; restart = 0;
        #2 rst_n = 0;
        repeat (2) @(posedge pclk);
        #1 rst_n = 1;
        model_reset();
    endtask

    // Present one pixel, then idle until its composite reaches rgb_out.
    task automatic show_pixel(int h, int v, logic [11:0] b, logic blank);
        hc = 11'(h); vc = 11'(v); bg = b; hb = blank; vb = 0; hs = 0; vs = 0;
        cycle();
        obs_xy = xy_o[0]; obs_line = line_o[0];
        sav_xy = exp_xy;  sav_line = exp_line;
        hc = 0; vc = 0; bg = 0; hb = 0;
        repeat (2) cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rgb_o[k] !== 12'h000 || done_o[k] !== 1'b0 || xy_o[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_init[%0d]: got rgb=%h done=%b xy=%h required 0", k, rgb_o[k], done_o[k], xy_o[k]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            hc = 11'($urandom_range(X0, X0 + 127)); vc = 11'($urandom_range(Y0, Y0 + 255));
            bg = 12'($urandom_range(1, 4095)); hs = 1; vs = 1;
            cycle();
        end
        #2 rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rgb_o[k] !== 12'h000 || xy_o[k] !== 8'h00 || line_o[k] !== 4'h0 ||
                done_o[k] !== 1'b0 || hc_o[k] !== 11'd0 || hs_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async[%0d]: got rgb=%h xy=%h line=%h done=%b hc=%0d hs=%b required all 0",
                         k, rgb_o[k], xy_o[k], line_o[k], done_o[k], hc_o[k], hs_o[k]);
            end
        end
        repeat (2) @(posedge pclk);
        #1 rst_n = 1;
        model_reset();
        hs = 0; vs = 0;
        frame_tick();
        font[0] = 8'hFF;
        show_pixel(X0, Y0, 12'h0F0, 0);
        checks++;
        if (rgb_o[1] !== 12'h0F0) begin
            errors++; $display("FAIL reset_first_tick: got %h required %h", rgb_o[1], 12'h0F0);
        end
        checks++;
        if (rgb_o[0] !== exp_rgb[0]) begin
            errors++; $display("FAIL reset_first_tick_a: got %h required %h", rgb_o[0], exp_rgb[0]);
        end
    endtask

    task automatic test_addressing();
        hc = 11'(X0 + 9); vc = 11'(Y0 + 17); hs = 1; bg = 12'h123;
        cycle();
        checks++;
        if (xy_o[0] !== 8'h11 || line_o[0] !== 4'd1) begin
            errors++; $display("FAIL addr: got xy=%h line=%0d required xy=11 line=1", xy_o[0], line_o[0]);
        end
        hs = 0;
        cycle();
        cycle();
        checks++;
        if (hs_o[0] !== 1'b1 || hc_o[0] !== 11'(X0 + 9) || vc_o[1] !== 11'(Y0 + 17)) begin
            errors++; $display("FAIL latency: got hs=%b hc=%0d vc=%0d required hs=1 hc=%0d vc=%0d",
                               hs_o[0], hc_o[0], vc_o[1], X0 + 9, Y0 + 17);
        end
        cycle();
        checks++;
        if (hs_o[0] !== 1'b0) begin
            errors++; $display("FAIL latency_end: got hs=%b required 0", hs_o[0]);
        end
    endtask

    task automatic test_pixel_select();
        reset_dut();
        repeat (2) frame_tick();
        font[0]  = 8'h80;
        font[32] = 8'hFF;
        show_pixel(X0, Y0, 12'h123, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rgb_o[k] !== 12'hFFF) begin
                errors++; $display("FAIL pix_set[%0d]: got %h required fff", k, rgb_o[k]);
            end
        end
        show_pixel(X0 + 1, Y0, 12'h456, 0);
        checks++;
        if (rgb_o[0] !== 12'h456) begin
            errors++; $display("FAIL pix_clear: got %h required 456", rgb_o[0]);
        end
        show_pixel(X0 + 16, Y0, 12'h789, 0);
        checks++;
        if (sav_xy !== 8'h02 || obs_xy !== sav_xy || rgb_o[0] !== 12'h789) begin
            errors++; $display("FAIL pix_unrevealed: got xy=%h rgb=%h required xy=02 rgb=789", obs_xy, rgb_o[0]);
        end
    endtask

    task automatic test_reveal_rate();
        reset_dut();
        repeat (10) frame_tick();
        for (int c = 0; c < 6; c++) font[c * 16] = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            show_pixel(X0 + 8 * c, Y0, 12'h0A5, 0);
            checks++;
            if (rgb_o[1] !== ((c < 5) ? 12'hFFF : 12'h0A5) || rgb_o[0] !== 12'hFFF) begin
                errors++; $display("FAIL rate char %0d: got a=%h b=%h required a=fff b=%h",
                                   c, rgb_o[0], rgb_o[1], (c < 5) ? 12'hFFF : 12'h0A5);
            end
        end
    endtask

    task automatic test_completion_restart();
        reset_dut();
        repeat (511) frame_tick();
        checks++;
        if (done_o[1] !== 1'b0 || done_o[0] !== 1'b1) begin
            errors++; $display("FAIL done_early: got a=%b b=%b required a=1 b=0", done_o[0], done_o[1]);
        end
        frame_tick();
        checks++;
        if (done_o[1] !== 1'b1 || done_o[0] !== 1'b1) begin
            errors++; $display("FAIL done_set: got a=%b b=%b required 1 1", done_o[0], done_o[1]);
        end
        font[255 * 16 + 15] = 8'hFF;
        show_pixel(X0 + 127, Y0 + 255, 12'h321, 0);
        checks++;
        if (rgb_o[0] !== 12'hFFF || rgb_o[1] !== 12'hFFF) begin
            errors++; $display("FAIL last_char: got a=%h b=%h required fff", rgb_o[0], rgb_o[1]);
        end
        restart = 1; cycle(); restart = 0;
        repeat (5) cycle();
        checks++;
        if (done_o[1] !== 1'b1 || done_o[0] !== 1'b1) begin
            errors++; $display("FAIL restart_midframe: got a=%b b=%b required 1 1", done_o[0], done_o[1]);
        end
        frame_tick();
        checks++;
        if (done_o[1] !== 1'b0 || done_o[0] !== 1'b0) begin
            errors++; $display("FAIL restart_tick: got a=%b b=%b required 0 0", done_o[0], done_o[1]);
        end
        font[0] = 8'hFF;
        show_pixel(X0, Y0, 12'h654, 0);
        checks++;
        if (rgb_o[0] !== 12'h654 || rgb_o[1] !== 12'h654) begin
            errors++; $display("FAIL restart_cleared: got a=%h b=%h required 654", rgb_o[0], rgb_o[1]);
        end
    endtask

    task automatic test_blank_edges();
        for (int l = 0; l < 16; l++) font[l] = 8'hFF;
        repeat (4) frame_tick();
        show_pixel(X0 + 2, Y0 + 3, 12'h5A5, 1);
        checks++;
        if (rgb_o[0] !== 12'h000) begin
            errors++; $display("FAIL hblank: got %h required 000", rgb_o[0]);
        end
        show_pixel(X0 - 1, Y0 + 5, 12'h3C3, 0);
        checks++;
        if (rgb_o[0] !== 12'h3C3) begin
            errors++; $display("FAIL left_edge: got %h required 3c3", rgb_o[0]);
        end
        show_pixel(X0 + 128, Y0 + 5, 12'h3C4, 0);
        checks++;
        if (rgb_o[0] !== 12'h3C4 || rgb_o[1] !== 12'h3C4) begin
            errors++; $display("FAIL right_edge: got a=%h b=%h required 3c4", rgb_o[0], rgb_o[1]);
        end
        show_pixel(X0 + 3, Y0 + 256, 12'h3C5, 0);
        checks++;
        if (rgb_o[0] !== 12'h3C5) begin
            errors++; $display("FAIL bottom_edge: got %h required 3c5", rgb_o[0]);
        end
        show_pixel(X0 + 3, Y0 + 255, 12'h3C6, 0);
        checks++;
        if (obs_xy[7:4] !== 4'hF || obs_line !== 4'hF || obs_xy !== sav_xy) begin
            errors++; $display("FAIL last_row: got xy=%h line=%h required row f line f (xy %h)", obs_xy, obs_line, sav_xy);
        end
    endtask

    task automatic test_random();
        logic vb_state = 0;
        for (int i = 0; i < 3000; i++) begin
            hc = 11'($urandom_range(30, 200));
            vc = 11'($urandom_range(50, 340));
            bg = 12'($urandom);
            hs = 1'($urandom); vs = 1'($urandom);
            hb = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) vb_state = ~vb_state;
            vb = vb_state;
            restart = ($urandom_range(0, 63) == 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rgb_o[k] !== exp_rgb[k]) begin
                    errors++; $display("FAIL rand_rgb[%0d] cyc %0d: got %h required %h", k, i, rgb_o[k], exp_rgb[k]);
                end
                checks++;
                if (done_o[k] !== exp_done[k]) begin
                    errors++; $display("FAIL rand_done[%0d] cyc %0d: got %b required %b", k, i, done_o[k], exp_done[k]);
                end
                checks++;
                if (xy_o[k] !== exp_xy || line_o[k] !== exp_line) begin
                    errors++; $display("FAIL rand_addr[%0d] cyc %0d: got %h/%h required %h/%h",
                                       k, i, xy_o[k], line_o[k], exp_xy, exp_line);
                end
                checks++;
                if ({hc_o[k], vc_o[k], hs_o[k], vs_o[k], hb_o[k], vb_o[k]} !== exp_tim) begin
                    errors++; $display("FAIL rand_timing[%0d] cyc %0d: got %h required %h", k, i,
                                       {hc_o[k], vc_o[k], hs_o[k], vs_o[k], hb_o[k], vb_o[k]}, exp_tim);
                end
            end
        end
        restart = 0;
        vb = 0;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        test_reset();
        test_addressing();
        test_pixel_select();
        test_reveal_rate();
        test_completion_restart();
        test_blank_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_reveal_ctl.md
Name: text_reveal_ctl

Overview:
- Sequences the 16x16 character ROM and the downstream font ROM to overlay a 128x256-pixel text box on the VGA pixel stream.
- Generates `char_xy` and `char_line` from the beam position and aligns the timing signals to the ROM latency.
- Reveals the text one character at a time, at a programmable frame rate, in typewriter fashion.
- Sits in the VGA pipeline between the background/rect stage and the output register stage.

Parameters:
- XPOS, 11'd48, left edge of the text box in pixels.
- YPOS, 11'd64, top edge of the text box in pixels.
- REVEAL_FRAMES, 4, frames per revealed character (legal range 1..255).
- TEXT_COLOR, 12'hFFF, RGB444 colour of set font pixels.

Ports:
- pclk  in  1  pixel clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hcount_in  in  11  horizontal beam position.
- vcount_in  in  11  vertical beam position.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing inputs.
- rgb_in  in  12  background pixel.
- restart  in  1  single-cycle pulse; restarts the reveal.
- char_xy  out  8  to the char ROM: {row[3:0], col[3:0]}.
- char_line  out  4  to the font ROM: line within the glyph.
- char_pixels  in  8  font ROM row; registered; valid 1 cycle after char_xy/char_line.
- hcount_out, vcount_out  out  11  timing delayed by 3 cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  timing delayed by 3 cycles.
- rgb_out  out  12  composited pixel.
- done  out  1  high once all 256 characters are revealed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0, including char_xy, char_line and done.
  - Pipelines clear; reveal_cnt=0; frame_cnt=0; restart_pend=0; FSM in REVEAL.
  - Reset asserted mid-frame takes effect immediately; the next frame after release starts the reveal from character 0.
- Geometry:
  - dx = hcount_in - XPOS; dy = vcount_in - YPOS (11 bits, unsigned).
  - in_box = (hcount_in >= XPOS) && (dx < 128) && (vcount_in >= YPOS) && (dy < 256).
  - Cell size is 8x16 pixels: col = dx[6:3], row = dy[7:4], line = dy[3:0].
- Pipeline:
  - Stage 1 (cycle +1): register char_xy={row,col} and char_line=line, even when outside the box. Also register in_box, dx[2:0], timing signals and rgb.
  - Stage 2 (cycle +2): char_pixels is valid. Delay timing, rgb, in_box and dx[2:0] one more cycle. Compute revealed = ({1'b0, char_xy_d} < reveal_cnt) in 9-bit compare.
  - Stage 3 (cycle +3): register the outputs.
  - Output latency is exactly 3 cycles for every signal.
- Pixel select (at stage 2): bit = char_pixels[7 - dx[2:0]].
- rgb_out priority:
  1. hblnk|vblnk (delayed) -> 12'h000.
  2. in_box & revealed & bit -> TEXT_COLOR.
  3. Otherwise -> rgb_in (delayed).
- Frame tick: one-cycle pulse on the rising edge of vblnk_in (registered edge detect).
- FSM states:
  - REVEAL: on each frame tick, frame_cnt increments. When frame_cnt == REVEAL_FRAMES-1, frame_cnt goes to 0 and reveal_cnt increments. When reveal_cnt becomes 256, go to DONE.
  - DONE: done=1; reveal_cnt holds at 256; frame ticks are ignored.
- restart:
  - Sets restart_pend in any state.
  - At the next frame tick: reveal_cnt=0, frame_cnt=0, restart_pend=0, state goes to REVEAL, done goes to 0.
  - A restart pending at that tick overrides any increment in the same cycle.
  - restart coincident with a frame tick is applied at that tick.
  - The displayed text never changes mid-frame.
- Width rules:
  - reveal_cnt is 9 bits with saturation at 256, never wrapping.
  - frame_cnt is 8 bits.
  - Subtractions are unsigned; the >= guards prevent wrap artefacts at the left and top edges.

Decomposition:
- Shared package `vga_pkg`:
  - Constants CHAR_W=8, CHAR_H=16, TEXT_COLS=16, TEXT_ROWS=16, BOX_W=128, BOX_H=256, PIPE_LAT=3.
  - Typedef for the reveal FSM state enum {REVEAL, DONE}.
- One natural sub-module, `reveal_sequencer`: frame-tick detect, frame_cnt, reveal_cnt, restart_pend and FSM.
- Datapath and pipeline stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-line with active inputs -> rgb_out=0, char_xy=0, done=0 within the same cycle (asynchronous); after release and 1 frame tick, reveal_cnt=0.
- Addressing/latency: hcount_in=XPOS+9, vcount_in=YPOS+17 -> char_xy=8'h11, char_line=1 at cycle +1; hsync_in pulse reappears on hsync_out at cycle +3.
- Pixel select: REVEAL_FRAMES=1, after 2 frames, char_pixels=8'h80 at dx[2:0]=0 of char 0 -> rgb_out=12'hFFF; at dx[2:0]=1 -> rgb_out=rgb_in; char_xy=8'h02 -> rgb_in, not revealed.
- Reveal rate: REVEAL_FRAMES=2, 10 frame ticks -> reveal_cnt=5; chars 0..4 drawn, char 5 shows background.
- Completion and restart: 512 ticks at REVEAL_FRAMES=2 -> done=1, reveal_cnt=256; restart mid-frame -> done stays 1 until the next vblnk rise, then done=0 and reveal_cnt=0.
- Blanking and edges: hblnk_in=1 inside the box -> rgb_out=0 at +3. hcount_in=XPOS-1 and XPOS+128 -> rgb_in passes. vcount_in=YPOS+255 -> char_xy row=15.
